// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: clips and buffers plotted pixels, drains them into a 160x120 frame-buffer write port, full-screen clear.
// Optional VGA_PIXEL_SINK_STATS_EN adds saturating write/clip counters.
module vga_pixel_sink #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        iClock,
  input  logic        iResetn,
  input  logic [7:0]  iX,
  input  logic [6:0]  iY,
  input  logic [2:0]  iColour,
  input  logic        iPlot,
  input  logic        iClear,
  input  logic [2:0]  iClearColour,
  input  logic        iMemReady,
  output logic [14:0] oAddr,
  output logic [2:0]  oData,
  output logic        oWrEn,
  output logic        oFull,
  output logic        oOverflow,
  output logic        oBusy,
  output logic        oDone
`ifdef VGA_PIXEL_SINK_STATS_EN
  ,
  output logic [15:0] oWriteCount,
  output logic [15:0] oClipCount
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [14:0] LAST = 15'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;
  state_t state;
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic clear_pend;
  logic [2:0] clr_col;
  logic on_screen, push, pop, xfer, clear_go;
  logic [14:0] pix_addr;
  assign on_screen = int'(iX) < X_SCREEN_PIXELS && int'(iY) < Y_SCREEN_PIXELS;
  assign oFull = count == CW'(FIFO_DEPTH);
  assign push = iPlot && on_screen && !oFull;
  // output register may reload when empty or its current write is being accepted
  assign xfer = !oWrEn || iMemReady;
  assign clear_go = state != S_CLEAR && (iClear || clear_pend) && xfer;
  assign pop = state != S_CLEAR && !(iClear || clear_pend) && count != '0 && xfer;
  assign pix_addr = ({8'b0, iY} << 7) + ({8'b0, iY} << 5) + {7'b0, iX};
  assign oBusy = state == S_CLEAR || count != '0 || oWrEn;
  always_ff @(posedge iClock)
    if (push) mem[wr_ptr] <= {pix_addr, iColour};
  always_ff @(posedge iClock or negedge iResetn)
    if (!iResetn) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      clear_pend <= 1'b0;
      clr_col <= '0;
      oAddr <= '0;
      oData <= '0;
      oWrEn <= 1'b0;
      oOverflow <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (iPlot && on_screen && oFull) oOverflow <= 1'b1;
      if (clear_go) begin
        state <= S_CLEAR;
        clear_pend <= 1'b0;
        oAddr <= '0;
        oData <= clear_pend ? clr_col : iClearColour;
        oWrEn <= 1'b1;
      end else if (state == S_CLEAR) begin
        if (iMemReady && oAddr == LAST) begin
          oWrEn <= 1'b0;
          oDone <= 1'b1;
          state <= (count != '0 || push) ? S_DRAIN : S_IDLE;
        end else if (iMemReady) oAddr <= oAddr + 1'b1;
      end else begin
        if (state == S_DRAIN && iClear && !clear_pend) begin
          clear_pend <= 1'b1;
          clr_col <= iClearColour;
        end
        if (xfer) oWrEn <= pop;
        if (pop) {oAddr, oData} <= mem[rd_ptr];
        state <= (push || count != '0 || (oWrEn && !iMemReady)) ? S_DRAIN : S_IDLE;
      end
    end
`ifdef VGA_PIXEL_SINK_STATS_EN
  always_ff @(posedge iClock or negedge iResetn)
    if (!iResetn) begin
      oWriteCount <= '0;
      oClipCount <= '0;
    end else begin
      if (oWrEn && iMemReady && state != S_CLEAR && oWriteCount != 16'hFFFF) oWriteCount <= oWriteCount + 1'b1;
      if (iPlot && !on_screen && oClipCount != 16'hFFFF) oClipCount <= oClipCount + 1'b1;
    end
`endif
endmodule
